score_display_ctrl: RTL and testbench



---
 rtl/score_display_ctrl_pkg.sv | 43 ++++
 rtl/score_display_ctrl_seg7_encode.sv | 32 +++
 rtl/score_display_ctrl.sv | 157 +++++++++++++++
 tb/tb_score_display_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_ctrl_pkg.sv
// Shared definitions for the score display controller.
//   - conv_state_t : binary->BCD conversion FSM states
//   - SEG_*        : active-low seven-segment codes, bit order {g,f,e,d,c,b,a}
//   - digit slots  : anode index of each displayed digit
//   - dd_step      : one double-dabble iteration on a {12-bit BCD, 8-bit bin} word
package score_disp_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [2:0] SCORE_ONES = 3'd0;
   localparam logic [2:0] SCORE_TENS = 3'd1;
   localparam logic [2:0] SCORE_HUND = 3'd2;
   localparam logic [2:0] HI_ONES    = 3'd4;
   localparam logic [2:0] HI_TENS    = 3'd5;
   localparam logic [2:0] HI_HUND    = 3'd6;

   // Eight shifts consume the 8-bit binary operand.
   localparam logic [3:0] SHIFT_LIMIT = 4'd8;

   // Add 3 to every BCD nibble >= 5, then shift the whole word left by one.
   function automatic logic [19:0] dd_step(input logic [19:0] sr);
      logic [19:0] adj;
      adj = sr;
      for (int i = 0; i < 3; i++) begin
         if (adj[8+4*i +: 4] >= 4'd5)
            adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
      end
      return {adj[18:0], 1'b0};
   endfunction

endpackage

// File: rtl/score_display_ctrl_seg7_encode.sv
// seg7_encode: BCD digit to active-low seven-segment pattern.
//   bcd   in  4  digit value 0..9 (anything larger renders blank)
//   blank in  1  force the digit dark
//   seg   out 7  cathodes {g,f,e,d,c,b,a}, active-low
module seg7_encode
   import score_disp_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: converts score/hiscore to BCD with a shared-timing
// double-dabble FSM, commits both results atomically, and scans an
// 8-digit active-low seven-segment display.
//   CLK            in  1  system clock
//   RST_BTN        in  1  synchronous active-high reset
//   score          in  8  current score, 0..255
//   hiscore        in  8  high score, 0..255
//   Anode_Activate out 8  digit enables, active-low, one-cold
//   LED_out        out 7  segment cathodes {g,f,e,d,c,b,a}, active-low
//   conv_busy      out 1  conversion in flight (LOAD/SHIFT/DONE)
// Parameter SCAN_DIV: clock cycles per digit slot (>= 1).
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zeros of the
// hundreds and tens digits; ones digit is always shown.
module score_display_ctrl
   import score_disp_pkg::*;
#(
   parameter int SCAN_DIV = 100000
) (
   input  logic       CLK,
   input  logic       RST_BTN,
   input  logic [7:0] score,
   input  logic [7:0] hiscore,
   output logic [7:0] Anode_Activate,
   output logic [6:0] LED_out,
   output logic       conv_busy
);

   localparam int             PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_TC   = PW'(SCAN_DIV - 1);
   localparam logic [3:0]     SHIFT_LAST = SHIFT_LIMIT - 4'd1;

   conv_state_t state, state_nxt;
   logic        force_flag;
   logic [7:0]  last_score, last_hi, cap_score, cap_hi;
   logic [19:0] sr_score, sr_hi;
   logic [3:0]  shift_cnt;
   logic [11:0] disp_score, disp_hi;

   logic [PW-1:0] presc;
   logic [2:0]    digit_idx, idx_nxt;
   logic [3:0]    mux_bcd;
   logic          mux_blank;
   logic [6:0]    seg;
   logic          s_hund_blank, s_tens_blank, h_hund_blank, h_tens_blank;

   // ---------------- conversion FSM ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (force_flag || score != last_score || hiscore != last_hi)
                     state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (shift_cnt == SHIFT_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign conv_busy = (state != IDLE);

   // Inputs are only looked at in IDLE (compare) and LOAD (capture), so a
   // change mid-conversion is picked up by the next IDLE compare.
   always_ff @(posedge CLK) begin
      if (RST_BTN) begin
         state      <= IDLE;
         force_flag <= 1'b1;
         last_score <= '0;
         last_hi    <= '0;
         cap_score  <= '0;
         cap_hi     <= '0;
         sr_score   <= '0;
         sr_hi      <= '0;
         shift_cnt  <= '0;
         disp_score <= '0;
         disp_hi    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            LOAD: begin
               sr_score   <= {12'd0, score};
               sr_hi      <= {12'd0, hiscore};
               cap_score  <= score;
               cap_hi     <= hiscore;
               shift_cnt  <= '0;
               force_flag <= 1'b0;
            end
            SHIFT: begin
               sr_score  <= dd_step(sr_score);
               sr_hi     <= dd_step(sr_hi);
               shift_cnt <= shift_cnt + 4'd1;
            end
            DONE: begin
               disp_score <= sr_score[19:8];
               disp_hi    <= sr_hi[19:8];
               last_score <= cap_score;
               last_hi    <= cap_hi;
            end
            default: ;
         endcase
      end
   end

   // ---------------- leading-zero blanking ----------------
`ifdef LEADING_ZERO_BLANK_EN
   assign s_hund_blank = (disp_score[11:8] == 4'd0);
   assign s_tens_blank = (disp_score[11:4] == 8'd0);
   assign h_hund_blank = (disp_hi[11:8] == 4'd0);
   assign h_tens_blank = (disp_hi[11:4] == 8'd0);
`else
   assign s_hund_blank = 1'b0;
   assign s_tens_blank = 1'b0;
   assign h_hund_blank = 1'b0;
   assign h_tens_blank = 1'b0;
`endif

   // ---------------- scan ----------------
   // The mux selects the digit that becomes active on the next slot, so the
   // registered anode and cathodes change together.
   assign idx_nxt = digit_idx + 3'd1;

   always_comb begin
      mux_bcd   = 4'd0;
      mux_blank = 1'b1;
      case (idx_nxt)
         SCORE_ONES: begin mux_bcd = disp_score[3:0];  mux_blank = 1'b0;         end
         SCORE_TENS: begin mux_bcd = disp_score[7:4];  mux_blank = s_tens_blank; end
         SCORE_HUND: begin mux_bcd = disp_score[11:8]; mux_blank = s_hund_blank; end
         HI_ONES:    begin mux_bcd = disp_hi[3:0];     mux_blank = 1'b0;         end
         HI_TENS:    begin mux_bcd = disp_hi[7:4];     mux_blank = h_tens_blank; end
         HI_HUND:    begin mux_bcd = disp_hi[11:8];    mux_blank = h_hund_blank; end
         default:    begin mux_bcd = 4'd0;             mux_blank = 1'b1;         end
      endcase
   end

   seg7_encode u_enc (
      .bcd   (mux_bcd),
      .blank (mux_blank),
      .seg   (seg)
   );

   always_ff @(posedge CLK) begin
      if (RST_BTN) begin
         presc          <= '0;
         digit_idx      <= '0;
         Anode_Activate <= 8'b1111_1110;
         LED_out        <= SEG_0;
      end else if (presc == PRESC_TC) begin
         presc          <= '0;
         digit_idx      <= idx_nxt;
         Anode_Activate <= ~(8'd1 << idx_nxt);
         LED_out        <= seg;
      end else begin
         presc <= presc + PW'(1);
      end
   end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Testbench for score_display_ctrl. Two instances share all inputs:
// dut (SCAN_DIV=4) for scan timing, dut1 (SCAN_DIV=1) for fast full-display checks.
module tb_score_display_ctrl;

   logic       CLK = 1'b0;
   logic       RST_BTN = 1'b1;
   logic [7:0] score = 8'd0, hiscore = 8'd0;
   logic [7:0] an4, an1;
   logic [6:0] led4, led1;
   logic       busy4, busy1;
   int         n_checks = 0, n_fail = 0;

   always #5 CLK = ~CLK;

   score_display_ctrl #(.SCAN_DIV(4)) dut (
      .CLK(CLK), .RST_BTN(RST_BTN), .score(score), .hiscore(hiscore),
      .Anode_Activate(an4), .LED_out(led4), .conv_busy(busy4));

   score_display_ctrl #(.SCAN_DIV(1)) dut1 (
      .CLK(CLK), .RST_BTN(RST_BTN), .score(score), .hiscore(hiscore),
      .Anode_Activate(an1), .LED_out(led1), .conv_busy(busy1));

   typedef struct {
      logic [7:0] s, h;
      logic [3:0] sh, st, so, hh, ht, ho;
   } vec_t;
   vec_t vecs [6];

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] exp_led(input int idx, input logic [3:0] sh, st, so,
                                          input logic [3:0] hh, ht, ho);
      logic [3:0] d;
      logic       blank;
      d = 4'd0;
      blank = 1'b0;
      case (idx)
         0: d = so;
         1: begin d = st;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (sh == 4'd0) && (st == 4'd0);
`endif
         end
         2: begin d = sh;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (sh == 4'd0);
`endif
         end
         4: d = ho;
         5: begin d = ht;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (hh == 4'd0) && (ht == 4'd0);
`endif
         end
         6: begin d = hh;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (hh == 4'd0);
`endif
         end
         default: blank = 1'b1;
      endcase
      return blank ? 7'b1111111 : seg_of(d);
   endfunction

   function automatic int cold_idx(input logic [7:0] a);
      int r, n;
      r = -1;
      n = 0;
      for (int i = 0; i < 8; i++)
         if (!a[i]) begin r = i; n++; end
      return (n == 1) ? r : -1;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Waits (bounded) for conv_busy to reach v; cyc returns cycles taken.
   task automatic wait_busy(input logic v, input int budget, output int cyc);
      cyc = 0;
      while (busy1 !== v && cyc < budget) begin
         tick();
         cyc++;
      end
      check("busy wait", 32'(busy1), 32'(v));
   endtask

   // Samples dut1 for one full scan and checks every digit.
   task automatic check_display(input string nm, input logic [3:0] sh, st, so,
                                input logic [3:0] hh, ht, ho);
      logic [7:0] mask;
      int idx;
      mask = 8'd0;
      for (int k = 0; k < 8; k++) begin
         tick();
         idx = cold_idx(an1);
         check({nm, " one-cold"}, 32'(idx >= 0), 32'd1);
         if (idx >= 0) begin
            mask[idx] = 1'b1;
            check({nm, " led"}, 32'(led1), 32'(exp_led(idx, sh, st, so, hh, ht, ho)));
         end
      end
      check({nm, " coverage"}, 32'(mask), 32'hFF);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      logic [7:0] exp_an;
      logic [3:0] ph, pt, po;

      vecs[0] = '{8'd255, 8'd0,   4'd2, 4'd5, 4'd5, 4'd0, 4'd0, 4'd0};
      vecs[1] = '{8'd7,   8'd200, 4'd0, 4'd0, 4'd7, 4'd2, 4'd0, 4'd0};
      vecs[2] = '{8'd99,  8'd100, 4'd0, 4'd9, 4'd9, 4'd1, 4'd0, 4'd0};
      vecs[3] = '{8'd10,  8'd9,   4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd9};
      vecs[4] = '{8'd128, 8'd64,  4'd1, 4'd2, 4'd8, 4'd0, 4'd6, 4'd4};
      vecs[5] = '{8'd0,   8'd255, 4'd0, 4'd0, 4'd0, 4'd2, 4'd5, 4'd5};

      // Reset, release, then watch scan order and the forced conversion.
      repeat (3) @(posedge CLK);
      #1;
      for (int n = 0; n < 36; n++) begin
         if (n > 0) tick();
         exp_an = ~(8'd1 << ((n / 4) % 8));
         check("scan anode", 32'(an4), 32'(exp_an));
         check("scan led", 32'(led4), 32'(exp_led((n / 4) % 8, 0, 0, 0, 0, 0, 0)));
         check("reset busy", 32'(busy4), 32'((n >= 1) && (n <= 10)));
         if (n == 0) RST_BTN = 1'b0;
      end

      // Directed vectors.
      foreach (vecs[i]) begin
         score   = vecs[i].s;
         hiscore = vecs[i].h;
         wait_busy(1'b1, 3, c);
         check("vec busy start", 32'(c), 32'd1);
         wait_busy(1'b0, 15, c);
         check("vec busy length", 32'(c), 32'd10);
         check_display("vec", vecs[i].sh, vecs[i].st, vecs[i].so,
                       vecs[i].hh, vecs[i].ht, vecs[i].ho);
      end

      // Input change during the third SHIFT cycle: 123 commits, then 45.
      score = 8'd123;
      tick();
      check("mid load busy", 32'(busy1), 32'd1);
      repeat (3) tick();
      score = 8'd45;
      wait_busy(1'b0, 15, c);
      check("mid first length", 32'(c), 32'd7);
      check_display("mid 123", 4'd1, 4'd2, 4'd3, 4'd2, 4'd5, 4'd5);
      check("mid reconvert busy", 32'(busy1), 32'd1);
      wait_busy(1'b0, 15, c);
      check("mid second tail", 32'(c), 32'd3);
      check_display("mid 045", 4'd0, 4'd4, 4'd5, 4'd2, 4'd5, 4'd5);

      // Reset during the fifth SHIFT cycle.
      score = 8'd99;
      tick();
      check("rst load busy", 32'(busy1), 32'd1);
      repeat (5) tick();
      RST_BTN = 1'b1;
      tick();
      check("rst anode", 32'(an4), 32'hFE);
      check("rst led", 32'(led4), 32'h40);
      check("rst busy", 32'(busy4), 32'd0);
      check("rst anode1", 32'(an1), 32'hFE);
      check("rst led1", 32'(led1), 32'h40);
      check("rst busy1", 32'(busy1), 32'd0);
      RST_BTN = 1'b0;
      wait_busy(1'b1, 3, c);
      check("rst restart", 32'(c), 32'd1);
      wait_busy(1'b0, 15, c);
      check("rst conv length", 32'(c), 32'd10);
      check_display("rst 099", 4'd0, 4'd9, 4'd9, 4'd2, 4'd5, 4'd5);

      // Sweep on SCAN_DIV=1: old value through edge 11, new from edge 12.
      ph = 4'd0; pt = 4'd9; po = 4'd9;
      for (int v = 0; v < 100; v++) begin
         score = 8'(v);
         for (int k = 1; k <= 20; k++) begin
            tick();
            if (k >= 12)
               check("sweep new", 32'(led1),
                     32'(exp_led(cold_idx(an1), 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10),
                                 4'd2, 4'd5, 4'd5)));
            else
               check("sweep old", 32'(led1),
                     32'(exp_led(cold_idx(an1), ph, pt, po, 4'd2, 4'd5, 4'd5)));
         end
         ph = 4'(v / 100); pt = 4'((v / 10) % 10); po = 4'(v % 10);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
